// File: rtl/evm_ballot_controller.sv
// Officer/voter front end for the EVM core: power-on, ballot issue, vote pulses, close and tally readback.
// Vote lands 2 cycles after a single button edge; readback is fully stalled by voting_done; no other backpressure.
module evm_ballot_controller #(
  parameter int WIDTH          = 7,
  parameter int RES_LAT        = 2,
  parameter int BALLOT_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power_key,
  input  logic             officer_enable,
  input  logic             close_poll,
  input  logic [2:0]       btn_vote,
  output logic             switch_on_evm,
  output logic             candidate_ready,
  output logic             vote_candidate_1,
  output logic             vote_candidate_2,
  output logic             vote_candidate_3,
  output logic             voting_session_done,
  output logic [1:0]       display_results,
  output logic             display_winner,
  input  logic [2:0]       candidate_name,
  input  logic             invalid_results,
  input  logic [WIDTH-1:0] results,
  input  logic             voting_in_progress,
  input  logic             voting_done,
  output logic [WIDTH-1:0] count_c1,
  output logic [WIDTH-1:0] count_c2,
  output logic [WIDTH-1:0] count_c3,
  output logic [2:0]       winner_id,
  output logic [WIDTH-1:0] winner_count,
  output logic             winner_invalid,
  output logic [WIDTH+1:0] cast_count,
  output logic             tally_mismatch,
  output logic             tally_valid,
  output logic             vote_cast,
  output logic             vote_rejected,
  output logic             ballot_timeout
);

  localparam int TW = $clog2(BALLOT_TIMEOUT + 1);
  localparam int LW = $clog2(RES_LAT + 2);

  typedef enum logic [3:0] {
    S_OFF, S_WAIT_ON, S_READY, S_BALLOT, S_VOTE, S_CLOSE, S_READ, S_WINNER, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       btn_q, btn_prev, btn_edge, vote_sel_q;
  logic             single_edge, multi_edge;
  logic [TW-1:0]    timer_q;
  logic             timeout_hit;
  logic [LW-1:0]    slot_q;
  logic             slot_last;
  logic [1:0]       idx_q;
  logic             close_pending_q;
  logic [WIDTH+1:0] tally_sum;

  assign btn_edge    = btn_q & ~btn_prev;
  assign single_edge = (btn_edge != 3'd0) && ((btn_edge & (btn_edge - 3'd1)) == 3'd0);
  assign multi_edge  = (btn_edge != 3'd0) && !single_edge;
  assign timeout_hit = (timer_q == TW'(BALLOT_TIMEOUT - 1));
  assign slot_last   = (slot_q == LW'(RES_LAT));
  assign tally_sum   = {2'b00, count_c1} + {2'b00, count_c2} + {2'b00, count_c3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_OFF;
      btn_q           <= '0;
      btn_prev        <= '0;
      vote_sel_q      <= '0;
      timer_q         <= '0;
      slot_q          <= '0;
      idx_q           <= '0;
      close_pending_q <= 1'b0;
      cast_count      <= '0;
      count_c1        <= '0;
      count_c2        <= '0;
      count_c3        <= '0;
      winner_id       <= '0;
      winner_count    <= '0;
      winner_invalid  <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_vote;
      btn_prev <= btn_q;

      if (!power_key)
        close_pending_q <= 1'b0;
      else if (state_q == S_READY && close_pending_q)
        close_pending_q <= 1'b0;
      else if (close_poll && state_q != S_OFF)
        close_pending_q <= 1'b1;

      // A rejected multi-press deliberately leaves the timer running.
      timer_q <= (state_q == S_BALLOT) ? timer_q + TW'(1) : '0;

      if (state_q == S_BALLOT && single_edge)
        vote_sel_q <= btn_edge;

      if (state_q == S_READ || state_q == S_WINNER) begin
        if (slot_last) begin
          slot_q <= '0;
          if (state_q == S_READ) idx_q <= idx_q + 2'd1;
        end else begin
          slot_q <= slot_q + LW'(1);
        end
      end else begin
        slot_q <= '0;
        idx_q  <= '0;
      end

      if (state_q == S_READ && slot_last) begin
        case (idx_q)
          2'd0:    count_c1 <= results;
          2'd1:    count_c2 <= results;
          default: count_c3 <= results;
        endcase
      end

      if (state_q == S_WINNER && slot_last) begin
        winner_id      <= candidate_name;
        winner_count   <= results;
        winner_invalid <= invalid_results;
      end

      if (!power_key)
        cast_count <= '0;
      else if (state_q == S_VOTE && cast_count != '1)
        cast_count <= cast_count + (WIDTH+2)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:     if (power_key) state_d = S_WAIT_ON;
      S_WAIT_ON: if (voting_in_progress) state_d = S_READY;
      S_READY: begin
        if (close_pending_q)     state_d = S_CLOSE;
        else if (officer_enable) state_d = S_BALLOT;
      end
      S_BALLOT: begin
        if (single_edge)      state_d = S_VOTE;
        else if (timeout_hit) state_d = S_READY;
      end
      S_VOTE:   state_d = S_READY;
      S_CLOSE:  if (voting_done) state_d = S_READ;
      S_READ:   if (slot_last && idx_q == 2'd2) state_d = S_WINNER;
      S_WINNER: if (slot_last) state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_OFF;
    endcase
    if (!power_key) state_d = S_OFF;
  end

  always_comb begin
    switch_on_evm       = (state_q != S_OFF);
    candidate_ready     = (state_q == S_BALLOT) || (state_q == S_VOTE);
    vote_candidate_1    = (state_q == S_VOTE) && vote_sel_q[0];
    vote_candidate_2    = (state_q == S_VOTE) && vote_sel_q[1];
    vote_candidate_3    = (state_q == S_VOTE) && vote_sel_q[2];
    voting_session_done = (state_q == S_CLOSE);
    display_results     = (state_q == S_READ) ? idx_q : 2'b00;
    display_winner      = (state_q == S_WINNER);
    tally_valid         = (state_q == S_DONE);
    tally_mismatch      = (state_q == S_DONE) && (tally_sum != cast_count);
    vote_cast           = (state_q == S_VOTE);
    vote_rejected       = (state_q == S_BALLOT) && multi_edge;
    ballot_timeout      = (state_q == S_BALLOT) && timeout_hit && !single_edge;
  end

endmodule
